// File: rtl/uc_bcast_queue_if.sv
// Bundle between the unit clause arbiter (master) and the broadcast queue (slave).
// Carries the push side, the per-channel pop/head lanes and the status flags.
interface uc_bcast_queue_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int NUM_CH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic                           flush;
  logic                           push;
  logic [DATA_W-1:0]              push_data;
  logic [NUM_CH-1:0]              pop;
  logic                           full;
  logic                           almost_full;
  logic [NUM_CH-1:0]              empty;
  logic [NUM_CH-1:0][DATA_W-1:0]  qout;
  logic [NUM_CH-1:0][AW:0]        occ;
  logic                           overflow;

  modport master (
    output flush, push, push_data, pop,
    input  full, almost_full, empty, qout, occ, overflow
  );

  modport slave (
    input  flush, push, push_data, pop,
    output full, almost_full, empty, qout, occ, overflow
  );
endinterface

// File: rtl/uc_bcast_queue.sv
// Single-writer, NUM_CH-reader broadcast circular buffer with FWFT heads.
// An entry is reclaimed only once the slowest channel's read pointer has passed it.
module uc_bcast_queue #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int NUM_CH   = 4,
  parameter int AFULL_TH = 14
) (
  input logic             clk,
  input logic             rst,
  uc_bcast_queue_if.slave q
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] PTR_ZERO = (AW+1)'(0);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_V = (AW+1)'(AFULL_TH);

  logic [DATA_W-1:0]       mem_r [DEPTH];
  logic [AW:0]             wr_ptr_r;
  logic [AW:0]             rd_ptr_r [NUM_CH];
  logic                    overflow_r;

  logic [NUM_CH-1:0][AW:0] occ_s;
  logic [NUM_CH-1:0]       empty_s;
  logic                    full_s;
  logic                    afull_s;
  logic                    push_en_s;

  // Occupancy and flags derived from the registered pointers (wrap bit makes DEPTH distinct from 0)
  always_comb begin
    full_s  = 1'b0;
    afull_s = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      occ_s[i]   = wr_ptr_r - rd_ptr_r[i];
      empty_s[i] = (occ_s[i] == PTR_ZERO);
      full_s     = full_s | (occ_s[i] == DEPTH_V);
      afull_s    = afull_s | (occ_s[i] >= AFULL_V);
    end
    push_en_s = q.push & ~full_s & ~q.flush;
  end

  // First-word-fall-through head per channel, forced to zero when that channel is empty
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (empty_s[i]) begin
        q.qout[i] = {DATA_W{1'b0}};
      end else begin
        q.qout[i] = mem_r[rd_ptr_r[i][AW-1:0]];
      end
    end
  end

  assign q.occ         = occ_s;
  assign q.empty       = empty_s;
  assign q.full        = full_s;
  assign q.almost_full = afull_s;
  assign q.overflow    = overflow_r;

  // Storage: cleared by reset only; flush just rewinds the pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_r[j] <= {DATA_W{1'b0}};
      end
    end else if (push_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= q.push_data;
    end
  end

  // Pointer and sticky overflow update; full and empty are judged on pre-edge state
  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      wr_ptr_r   <= PTR_ZERO;
      overflow_r <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        rd_ptr_r[i] <= PTR_ZERO;
      end
    end else begin
      if (push_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      overflow_r <= overflow_r | (q.push & full_s);
      for (int i = 0; i < NUM_CH; i++) begin
        if (q.pop[i] && !empty_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_uc_bcast_queue.sv
// Self-checking bench for uc_bcast_queue: directed scenarios plus randomized traffic
// checked against a history-array model (one shared push log, per-channel consumed counts).
module tb_uc_bcast_queue;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int NUM_CH = 4;
  localparam int AFULL  = 14;
  localparam int HMAX   = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uc_bcast_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) bus ();

  uc_bcast_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .AFULL_TH(AFULL)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  int errors = 0;
  int checks = 0;

  // model: every accepted literal since the last flush/reset, and how many each channel consumed
  logic [DATA_W-1:0] hist [HMAX];
  int                wr_cnt;
  int                rd_cnt [NUM_CH];
  bit                m_ovf;

  logic [NUM_CH-1:0]             e_empty;
  logic [NUM_CH-1:0][DATA_W-1:0] e_qout;
  logic [NUM_CH-1:0][4:0]        e_occ;
  logic                          e_full, e_afull, e_ovf;

  task automatic model_expect();
    int o;
    e_full = 1'b0;
    e_afull = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      o = wr_cnt - rd_cnt[i];
      e_occ[i]   = 5'(o);
      e_empty[i] = (o == 0);
      e_qout[i]  = (o == 0) ? 8'h00 : hist[rd_cnt[i]];
      if (o == DEPTH) e_full = 1'b1;
      if (o >= AFULL) e_afull = 1'b1;
    end
    e_ovf = m_ovf;
  endtask

  // Drive one clock of stimulus, advance the model, leave time at edge+1 for sampling
  task automatic cycle(input bit p, input logic [7:0] d, input logic [3:0] pp, input bit f, input bit r);
    bit pre_full;
    pre_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) if (wr_cnt - rd_cnt[i] == DEPTH) pre_full = 1'b1;
    rst = r; bus.flush = f; bus.push = p; bus.push_data = d; bus.pop = pp;
    @(posedge clk);
    if (r || f) begin
      wr_cnt = 0;
      for (int i = 0; i < NUM_CH; i++) rd_cnt[i] = 0;
      m_ovf = 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) if (pp[i] && wr_cnt > rd_cnt[i]) rd_cnt[i]++;
      if (p && !pre_full) begin
        hist[wr_cnt] = d;
        wr_cnt++;
      end else if (p) begin
        m_ovf = 1'b1;
      end
    end
    #1;
    rst = 1'b0; bus.flush = 1'b0; bus.push = 1'b0; bus.pop = 4'h0;
    model_expect();
  endtask

  task automatic test_reset();
    cycle(1'b0, 8'h00, 4'h0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
    checks++; if (bus.empty !== 4'hF) begin errors++; $display("FAIL reset_empty got=%h exp=f", bus.empty); end
    checks++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL reset_flags got full=%b af=%b ovf=%b exp 0 0 0", bus.full, bus.almost_full, bus.overflow); end
    checks++; if (bus.qout !== 32'h0) begin errors++; $display("FAIL reset_qout got=%h exp=0", bus.qout); end
    checks++; if (bus.occ !== 20'h0) begin errors++; $display("FAIL reset_occ got=%h exp=0", bus.occ); end
  endtask

  task automatic test_basic();
    cycle(1'b1, 8'h11, 4'h0, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 4'h0, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 4'h0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 4'h1, 1'b0, 1'b0);
    checks++; if (bus.qout !== 32'h11111122) begin errors++; $display("FAIL basic_qout got=%h exp=11111122", bus.qout); end
    checks++; if (bus.occ !== {5'd3, 5'd3, 5'd3, 5'd2}) begin errors++; $display("FAIL basic_occ got=%h exp=%h", bus.occ, {5'd3, 5'd3, 5'd3, 5'd2}); end
    checks++; if (bus.empty !== 4'h0) begin errors++; $display("FAIL basic_empty got=%h exp=0", bus.empty); end
  endtask

  task automatic test_full();
    cycle(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      cycle(1'b1, 8'(k), 4'h0, 1'b0, 1'b0);
      checks++; if (bus.almost_full !== (k + 1 >= AFULL)) begin
        errors++; $display("FAIL full_afull k=%0d got=%b exp=%b", k, bus.almost_full, (k + 1 >= AFULL)); end
    end
    checks++; if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL full_set got full=%b ovf=%b exp 1 0", bus.full, bus.overflow); end
    cycle(1'b1, 8'hAA, 4'h0, 1'b0, 1'b0);
    checks++; if (bus.overflow !== 1'b1 || bus.occ !== {4{5'd16}}) begin
      errors++; $display("FAIL full_overflow got ovf=%b occ=%h exp 1 %h", bus.overflow, bus.occ, {4{5'd16}}); end
    for (int k = 0; k < DEPTH; k++) begin
      checks++; if (bus.qout[0] !== 8'(k) || bus.qout[3] !== 8'h00) begin
        errors++; $display("FAIL full_drain k=%0d got q0=%h q3=%h exp %h 00", k, bus.qout[0], bus.qout[3], 8'(k)); end
      cycle(1'b0, 8'h00, 4'h7, 1'b0, 1'b0);
      checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_hold k=%0d got=%b exp=1", k, bus.full); end
    end
    checks++; if (bus.empty !== 4'h7 || bus.occ[3] !== 5'd16) begin
      errors++; $display("FAIL full_slowest got empty=%h occ3=%0d exp 7 16", bus.empty, bus.occ[3]); end
    cycle(1'b0, 8'h00, 4'h8, 1'b0, 1'b0);
    checks++; if (bus.full !== 1'b0 || bus.qout[3] !== 8'h01) begin
      errors++; $display("FAIL full_release got full=%b q3=%h exp 0 01", bus.full, bus.qout[3]); end
  endtask

  task automatic test_wrap();
    cycle(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      cycle(1'b1, 8'(k), 4'hF, 1'b0, 1'b0);
      checks++; if (bus.qout !== {4{8'(k)}} || bus.occ !== {4{5'd1}}) begin
        errors++; $display("FAIL wrap k=%0d got qout=%h occ=%h exp %h %h", k, bus.qout, bus.occ, {4{8'(k)}}, {4{5'd1}}); end
    end
  endtask

  task automatic test_push_pop_empty();
    cycle(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    cycle(1'b1, 8'h5A, 4'h1, 1'b0, 1'b0);
    checks++; if (bus.empty[0] !== 1'b0 || bus.qout[0] !== 8'h5A || bus.occ[0] !== 5'd1) begin
      errors++; $display("FAIL pp_empty got e=%b q=%h occ=%0d exp 0 5a 1", bus.empty[0], bus.qout[0], bus.occ[0]); end
  endtask

  task automatic test_flush(input bit use_rst);
    cycle(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    for (int k = 0; k < DEPTH + 1; k++) cycle(1'b1, 8'(8'hC0 + k), 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < DEPTH - 5; k++) cycle(1'b0, 8'h00, 4'hF, 1'b0, 1'b0);
    checks++; if (bus.overflow !== 1'b1 || bus.occ !== {4{5'd5}}) begin
      errors++; $display("FAIL flush_pre rst=%0d got ovf=%b occ=%h exp 1 %h", use_rst, bus.overflow, bus.occ, {4{5'd5}}); end
    cycle(1'b1, 8'hEE, 4'hF, !use_rst, use_rst);
    checks++; if (bus.empty !== 4'hF || bus.occ !== 20'h0 || bus.qout !== 32'h0 || bus.overflow !== 1'b0 || bus.full !== 1'b0) begin
      errors++; $display("FAIL flush_clear rst=%0d got e=%h occ=%h q=%h ovf=%b full=%b exp f 0 0 0 0",
                         use_rst, bus.empty, bus.occ, bus.qout, bus.overflow, bus.full); end
    cycle(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
    checks++; if (bus.empty !== 4'hF) begin errors++; $display("FAIL flush_nowrite rst=%0d got e=%h exp f", use_rst, bus.empty); end
  endtask

  task automatic test_random();
    int pw;
    logic [3:0] pp;
    cycle(1'b0, 8'h00, 4'h0, 1'b0, 1'b1);
    for (int k = 0; k < 1500; k++) begin
      pw = ((k / 150) % 2 == 0) ? 85 : 30;
      pp = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 99) < pw, 8'($urandom), pp,
            $urandom_range(0, 199) == 0, $urandom_range(0, 399) == 0);
      checks++;
      if ({bus.empty, bus.full, bus.almost_full, bus.overflow, bus.occ, bus.qout} !==
          {e_empty, e_full, e_afull, e_ovf, e_occ, e_qout}) begin
        errors++;
        $display("FAIL random k=%0d got e=%h f=%b af=%b ov=%b occ=%h q=%h exp e=%h f=%b af=%b ov=%b occ=%h q=%h",
                 k, bus.empty, bus.full, bus.almost_full, bus.overflow, bus.occ, bus.qout,
                 e_empty, e_full, e_afull, e_ovf, e_occ, e_qout);
      end
    end
  endtask

  initial begin
    bus.flush = 1'b0; bus.push = 1'b0; bus.push_data = 8'h00; bus.pop = 4'h0;
    wr_cnt = 0; m_ovf = 1'b0;
    for (int i = 0; i < NUM_CH; i++) rd_cnt[i] = 0;
    #2;
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_push_pop_empty();
    test_flush(1'b0);
    test_flush(1'b1);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
